// File: rtl/rhs_stim_sequencer.sv
// -----------------------------------------------------------------------------
// rhs_stim_sequencer
//
// Stimulation pulse-train sequencer for the RHS multi-chip front end. Once per
// sample frame (frame_tick) it decides whether each channel is driven anodic,
// driven cathodic, in charge recovery, or idle.
//
// A train is a series of bipulses: PHASE1 -> GAP_P -> PHASE2, separated by
// GAP_B. Each train ends in RECOVERY. Trains are separated by GAP_T.
// States with a zero duration are skipped in the same evaluation, and skips
// chain.
//
// Parameters:
//   N_CH   number of stimulable channels per mask
//   CNT_W  width of all duration and count inputs
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   frame_tick           one-cycle pulse per SPI frame (time base)
//   finite_start         start a finite run of train_count trains
//   infinite_start       start an endless run
//   infinite_stop        graceful stop of an endless run
//   pulse_length .. train_count   durations/counts in frame ticks
//                        (latched at start)
//   magnitude_in         current magnitude code
//   rising_edge_first    1 = PHASE1 is anodic
//   bipolar_mode         drive mask_neg with the opposite polarity
//   mask_pos, mask_neg   channel masks
//   drive_anodic/_cathodic  per-channel drive, registered
//   magnitude_out        latched magnitude while a phase is active, else 0
//   charge_recovery      high in RECOVERY
//   busy                 high when not IDLE
//   done                 one-cycle pulse on return to IDLE
//   param_error          one-cycle pulse when a start is rejected
//   state_dbg            current FSM state encoding, for observation only
//
// Handshake: all command inputs are single-cycle pulses sampled on clk. There
// is no back-pressure. A start is acted on only in IDLE; starts at any other
// time are dropped silently.
//
// Build option: define RHS_STIM_INFINITE_EN to enable infinite mode and the
// graceful stop. Without it, infinite_start/infinite_stop are ignored and
// only finite runs exist.
// -----------------------------------------------------------------------------
module rhs_stim_sequencer #(
  parameter int N_CH  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_tick,
  input  logic             finite_start,
  input  logic             infinite_start,
  input  logic             infinite_stop,
  input  logic [CNT_W-1:0] pulse_length,
  input  logic [CNT_W-1:0] inter_pulse_delay,
  input  logic [CNT_W-1:0] inter_bipulse_delay,
  input  logic [CNT_W-1:0] inter_train_delay,
  input  logic [CNT_W-1:0] charge_recovery_time,
  input  logic [CNT_W-1:0] bipulses_per_train,
  input  logic [CNT_W-1:0] train_count,
  input  logic [7:0]       magnitude_in,
  input  logic             rising_edge_first,
  input  logic             bipolar_mode,
  input  logic [N_CH-1:0]  mask_pos,
  input  logic [N_CH-1:0]  mask_neg,
  output logic [N_CH-1:0]  drive_anodic,
  output logic [N_CH-1:0]  drive_cathodic,
  output logic [7:0]       magnitude_out,
  output logic             charge_recovery,
  output logic             busy,
  output logic             done,
  output logic             param_error,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_PHASE1   = 3'd2,
    S_GAP_P    = 3'd3,
    S_PHASE2   = 3'd4,
    S_GAP_B    = 3'd5,
    S_RECOVERY = 3'd6,
    S_GAP_T    = 3'd7
  } state_e;

  state_e state_q, state_d;

  // Shadow copies of the configuration, captured on an accepted start.
  logic [CNT_W-1:0] pl_q, ipd_q, ibd_q, itd_q, crt_q, bpt_q, tc_q;
  logic [7:0]       mag_q;
  logic             ref_q, bipol_q;
  logic [N_CH-1:0]  mpos_q, mneg_q;

  // Per-state frame-tick timer and repetition counters.
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] bip_cnt_q, bip_cnt_d;
  logic [CNT_W-1:0] train_cnt_q, train_cnt_d;

  // Registered outputs.
  logic [N_CH-1:0]  drv_a_q, drv_a_d;
  logic [N_CH-1:0]  drv_c_q, drv_c_d;
  logic [7:0]       mag_out_q, mag_out_d;
  logic             rec_q, rec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;

  // Start decode.
  logic start_any;
  logic start_is_finite;
  logic start_bad;
  logic start_accept;
  logic start_reject;

  // Infinite-mode state; constant 0 when the feature is not built.
  logic inf_mode;
  logic stop_now;

`ifdef RHS_STIM_INFINITE_EN
  logic inf_mode_q, inf_mode_d;
  logic stop_pend_q, stop_pend_d;

  // A stop together with a start in IDLE cancels the start; finite wins
  // over infinite when both starts arrive together.
  assign start_any       = (finite_start || infinite_start) && !infinite_stop;
  assign start_is_finite = finite_start;
  assign inf_mode        = inf_mode_q;
  // Stop request in effect this cycle: a latched one or a fresh pulse.
  assign stop_now        = inf_mode_q && (stop_pend_q || infinite_stop);

  always_comb begin
    inf_mode_d  = inf_mode_q;
    stop_pend_d = stop_pend_q;
    if (start_accept) begin
      inf_mode_d = !finite_start;
    end
    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end else if (inf_mode_q && infinite_stop && (state_q != S_IDLE)) begin
      stop_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inf_mode_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      inf_mode_q  <= inf_mode_d;
      stop_pend_q <= stop_pend_d;
    end
  end
`else
  logic unused_inf_cmds;
  assign unused_inf_cmds = infinite_start ^ infinite_stop;
  assign start_any       = finite_start;
  assign start_is_finite = 1'b1;
  assign inf_mode        = 1'b0;
  assign stop_now        = 1'b0;
`endif

  assign start_bad = (pulse_length == '0) || (bipulses_per_train == '0) ||
                     (start_is_finite && (train_count == '0));

  // Duration of the current timed state.
  logic [CNT_W-1:0] cur_dur;
  always_comb begin
    cur_dur = pl_q;
    case (state_q)
      S_GAP_P:    cur_dur = ipd_q;
      S_GAP_B:    cur_dur = ibd_q;
      S_RECOVERY: cur_dur = crt_q;
      S_GAP_T:    cur_dur = itd_q;
      default:    cur_dur = pl_q;
    endcase
  end

  logic [CNT_W-1:0] tick_inc, bip_inc, train_inc;
  logic             last_bip;
  logic             run_over_p2, run_over_rec;
  state_e           next_train_st;

  assign tick_inc  = tick_q + CNT_W'(1);
  assign bip_inc   = bip_cnt_q + CNT_W'(1);
  assign train_inc = train_cnt_q + CNT_W'(1);
  assign last_bip  = (bip_inc == bpt_q);
  // End-of-run test when leaving PHASE2 directly (recovery skipped) uses the
  // count that includes the train just finished; from RECOVERY the counter
  // has already advanced.
  assign run_over_p2   = inf_mode ? stop_now : (train_inc == tc_q);
  assign run_over_rec  = inf_mode ? stop_now : (train_cnt_q == tc_q);
  assign next_train_st = (itd_q == '0) ? S_PHASE1 : S_GAP_T;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bip_cnt_d    = bip_cnt_q;
    train_cnt_d  = train_cnt_q;
    start_accept = 1'b0;
    start_reject = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_any) begin
          if (start_bad) begin
            start_reject = 1'b1;
          end else begin
            start_accept = 1'b1;
            state_d      = S_ARMED;
            tick_d       = '0;
            bip_cnt_d    = '0;
            train_cnt_d  = '0;
          end
        end
      end
      S_ARMED: begin
        if (frame_tick) begin
          state_d = S_PHASE1;
          tick_d  = '0;
        end
      end
      default: begin
        if (frame_tick) begin
          if ((state_q == S_GAP_T) && stop_now) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (tick_inc == cur_dur) begin
            tick_d = '0;
            case (state_q)
              S_PHASE1: state_d = (ipd_q == '0) ? S_PHASE2 : S_GAP_P;
              S_GAP_P:  state_d = S_PHASE2;
              S_PHASE2: begin
                if (!last_bip) begin
                  bip_cnt_d = bip_inc;
                  state_d   = (ibd_q == '0) ? S_PHASE1 : S_GAP_B;
                end else begin
                  bip_cnt_d = '0;
                  // Infinite runs never advance the train counter.
                  if (!inf_mode) begin
                    train_cnt_d = train_inc;
                  end
                  if (crt_q != '0) begin
                    state_d = S_RECOVERY;
                  end else begin
                    state_d = run_over_p2 ? S_IDLE : next_train_st;
                  end
                end
              end
              S_GAP_B:    state_d = S_PHASE1;
              S_RECOVERY: state_d = run_over_rec ? S_IDLE : next_train_st;
              S_GAP_T:    state_d = S_PHASE1;
              default:    state_d = S_IDLE;
            endcase
          end else begin
            tick_d = tick_inc;
          end
        end
      end
    endcase
  end

  // Output decode from the next state, so outputs line up with state_q.
  logic phase_act, anodic_now;
  logic [N_CH-1:0] neg_drv;

  always_comb begin
    phase_act  = (state_d == S_PHASE1) || (state_d == S_PHASE2);
    // PHASE1 takes the polarity of rising_edge_first, PHASE2 the opposite.
    anodic_now = (state_d == S_PHASE1) ? ref_q : !ref_q;
    neg_drv    = bipol_q ? mneg_q : '0;
    drv_a_d    = '0;
    drv_c_d    = '0;
    mag_out_d  = 8'h00;
    if (phase_act) begin
      mag_out_d = mag_q;
      if (anodic_now) begin
        drv_a_d = mpos_q;
        drv_c_d = neg_drv;
      end else begin
        drv_a_d = neg_drv;
        drv_c_d = mpos_q;
      end
    end
    rec_d  = (state_d == S_RECOVERY);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    perr_d = start_reject;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bip_cnt_q   <= '0;
      train_cnt_q <= '0;
      pl_q        <= '0;
      ipd_q       <= '0;
      ibd_q       <= '0;
      itd_q       <= '0;
      crt_q       <= '0;
      bpt_q       <= '0;
      tc_q        <= '0;
      mag_q       <= 8'h00;
      ref_q       <= 1'b0;
      bipol_q     <= 1'b0;
      mpos_q      <= '0;
      mneg_q      <= '0;
      drv_a_q     <= '0;
      drv_c_q     <= '0;
      mag_out_q   <= 8'h00;
      rec_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bip_cnt_q   <= bip_cnt_d;
      train_cnt_q <= train_cnt_d;
      if (start_accept) begin
        pl_q    <= pulse_length;
        ipd_q   <= inter_pulse_delay;
        ibd_q   <= inter_bipulse_delay;
        itd_q   <= inter_train_delay;
        crt_q   <= charge_recovery_time;
        bpt_q   <= bipulses_per_train;
        tc_q    <= train_count;
        mag_q   <= magnitude_in;
        ref_q   <= rising_edge_first;
        bipol_q <= bipolar_mode;
        mpos_q  <= mask_pos;
        mneg_q  <= mask_neg;
      end
      drv_a_q   <= drv_a_d;
      drv_c_q   <= drv_c_d;
      mag_out_q <= mag_out_d;
      rec_q     <= rec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
    end
  end

  assign drive_anodic    = drv_a_q;
  assign drive_cathodic  = drv_c_q;
  assign magnitude_out   = mag_out_q;
  assign charge_recovery = rec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign param_error     = perr_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rhs_stim_sequencer
//
// Directed bench for rhs_stim_sequencer. A free-running frame_tick fires
// every fourth clock. Each scenario task sets up a configuration, issues
// commands, and observes a whole run through the measure task, which counts
// frame ticks per output condition. It then compares against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_rhs_stim_sequencer;
  localparam int N_CH  = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             frame_tick;
  logic             finite_start, infinite_start, infinite_stop;
  logic [CNT_W-1:0] pulse_length, inter_pulse_delay, inter_bipulse_delay;
  logic [CNT_W-1:0] inter_train_delay, charge_recovery_time;
  logic [CNT_W-1:0] bipulses_per_train, train_count;
  logic [7:0]       magnitude_in;
  logic             rising_edge_first, bipolar_mode;
  logic [N_CH-1:0]  mask_pos, mask_neg;
  logic [N_CH-1:0]  drive_anodic, drive_cathodic;
  logic [7:0]       magnitude_out;
  logic             charge_recovery, busy, done, param_error;
  logic [2:0]       state_dbg;

  int n_vec = 0;
  int n_err = 0;

  rhs_stim_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .finite_start(finite_start), .infinite_start(infinite_start),
    .infinite_stop(infinite_stop),
    .pulse_length(pulse_length), .inter_pulse_delay(inter_pulse_delay),
    .inter_bipulse_delay(inter_bipulse_delay),
    .inter_train_delay(inter_train_delay),
    .charge_recovery_time(charge_recovery_time),
    .bipulses_per_train(bipulses_per_train), .train_count(train_count),
    .magnitude_in(magnitude_in), .rising_edge_first(rising_edge_first),
    .bipolar_mode(bipolar_mode), .mask_pos(mask_pos), .mask_neg(mask_neg),
    .drive_anodic(drive_anodic), .drive_cathodic(drive_cathodic),
    .magnitude_out(magnitude_out), .charge_recovery(charge_recovery),
    .busy(busy), .done(done), .param_error(param_error),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / frame tick ----------------
  initial forever #5 clk = ~clk;

  int tick_div = 0;
  initial begin
    frame_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div   = (tick_div + 1) % 4;
      frame_tick = (tick_div == 0);
    end
  end

  // ---------------- measurement results ----------------
  int         m_ticks, m_drive_ticks, m_rec_ticks, m_rec_cycles;
  int         m_done, m_perr, m_entries, m_swaps, m_mag_bad, m_after_stop;
  bit         m_timeout;
  logic [15:0] m_p1a, m_p1c, m_p2a, m_p2c;
  int         stop_entry = 0;
  bit         stop_in_gapt = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int pl, input int ipd, input int ibd,
                         input int bpt, input int tc, input int crt,
                         input int itd, input bit ref_first, input bit bip);
    pulse_length         = CNT_W'(pl);
    inter_pulse_delay    = CNT_W'(ipd);
    inter_bipulse_delay  = CNT_W'(ibd);
    bipulses_per_train   = CNT_W'(bpt);
    train_count          = CNT_W'(tc);
    charge_recovery_time = CNT_W'(crt);
    inter_train_delay    = CNT_W'(itd);
    rising_edge_first    = ref_first;
    bipolar_mode         = bip;
    mask_pos             = 16'h0080;
    mask_neg             = 16'h8000;
    magnitude_in         = 8'h5A;
  endtask

  task automatic pulse_finite();
    @(posedge clk); #1 finite_start = 1'b1;
    @(posedge clk); #1 finite_start = 1'b0;
  endtask

  task automatic pulse_infinite(input bit with_stop);
    @(posedge clk); #1 infinite_start = 1'b1; infinite_stop = with_stop;
    @(posedge clk); #1 infinite_start = 1'b0; infinite_stop = 1'b0;
  endtask

  // Observes one run until four cycles after busy falls, or cycle budget.
  task automatic measure(input int max_cyc);
    logic [2*N_CH-1:0] cur, prev;
    bit seen_busy, started, prev_rec, stop_sent;
    int idle_cyc;
    cur = '0; prev = '0; seen_busy = 0; started = 0; prev_rec = 0;
    stop_sent = 0; idle_cyc = 0;
    m_ticks = 0; m_drive_ticks = 0; m_rec_ticks = 0; m_rec_cycles = 0;
    m_done = 0; m_perr = 0; m_entries = 0; m_swaps = 0; m_mag_bad = 0;
    m_after_stop = 0; m_timeout = 1'b1;
    m_p1a = '0; m_p1c = '0; m_p2a = '0; m_p2c = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (infinite_stop) infinite_stop = 1'b0;
      cur = {drive_anodic, drive_cathodic};
      if (busy) seen_busy = 1'b1;
      if (cur != '0) started = 1'b1;
      if ((cur != '0) && (cur != prev)) begin
        m_entries++;
        if (prev != '0) m_swaps++;
        if (m_entries == 1) begin m_p1a = drive_anodic; m_p1c = drive_cathodic; end
        if (m_entries == 2) begin m_p2a = drive_anodic; m_p2c = drive_cathodic; end
        if ((stop_entry != 0) && (m_entries == stop_entry)) infinite_stop = 1'b1;
      end
      if (stop_in_gapt && !stop_sent && prev_rec && !charge_recovery && busy) begin
        infinite_stop = 1'b1;
        stop_sent     = 1'b1;
      end
      if (busy && frame_tick) begin
        if (started) m_ticks++;
        if (cur != '0) m_drive_ticks++;
        if (charge_recovery) m_rec_ticks++;
        if (stop_sent) m_after_stop++;
      end
      if (charge_recovery) m_rec_cycles++;
      if (done) m_done++;
      if (param_error) m_perr++;
      if (magnitude_out !== ((cur != '0) ? magnitude_in : 8'h00)) m_mag_bad++;
      prev     = cur;
      prev_rec = charge_recovery;
      if (seen_busy && !busy) begin
        idle_cyc++;
        if (idle_cyc == 4) begin
          m_timeout = 1'b0;
          break;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++; if (drive_anodic !== 16'h0) begin n_err++; $display("FAIL reset_anodic: got %h expected 0", drive_anodic); end
    n_vec++; if (drive_cathodic !== 16'h0) begin n_err++; $display("FAIL reset_cathodic: got %h expected 0", drive_cathodic); end
    n_vec++; if (magnitude_out !== 8'h0) begin n_err++; $display("FAIL reset_magnitude: got %h expected 0", magnitude_out); end
    n_vec++; if (charge_recovery !== 1'b0) begin n_err++; $display("FAIL reset_recovery: got %b expected 0", charge_recovery); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (param_error !== 1'b0) begin n_err++; $display("FAIL reset_param_error: got %b expected 0", param_error); end
  endtask

  task automatic test_full_sequence();
    set_cfg(1, 3, 3, 4, 4, 8, 11, 1'b1, 1'b1);
    pulse_finite();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy_after_start: got %b expected 1", busy); end
    measure(2000);
    n_vec++; if (m_timeout) begin n_err++; $display("FAIL full_timeout: got no return to idle expected idle"); end
    n_vec++; if (m_ticks !== 181) begin n_err++; $display("FAIL full_ticks: got %0d expected 181", m_ticks); end
    n_vec++; if (m_drive_ticks !== 32) begin n_err++; $display("FAIL full_drive_ticks: got %0d expected 32", m_drive_ticks); end
    n_vec++; if (m_rec_ticks !== 32) begin n_err++; $display("FAIL full_recovery_ticks: got %0d expected 32", m_rec_ticks); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL full_done_count: got %0d expected 1", m_done); end
    n_vec++; if (m_perr !== 0) begin n_err++; $display("FAIL full_param_error: got %0d expected 0", m_perr); end
    n_vec++; if (m_p1a !== 16'h0080) begin n_err++; $display("FAIL bipolar_p1_anodic: got %h expected 0080", m_p1a); end
    n_vec++; if (m_p1c !== 16'h8000) begin n_err++; $display("FAIL bipolar_p1_cathodic: got %h expected 8000", m_p1c); end
    n_vec++; if (m_p2a !== 16'h8000) begin n_err++; $display("FAIL bipolar_p2_anodic: got %h expected 8000", m_p2a); end
    n_vec++; if (m_p2c !== 16'h0080) begin n_err++; $display("FAIL bipolar_p2_cathodic: got %h expected 0080", m_p2c); end
    n_vec++; if (m_swaps !== 0) begin n_err++; $display("FAIL full_direct_swaps: got %0d expected 0", m_swaps); end
    n_vec++; if (m_mag_bad !== 0) begin n_err++; $display("FAIL full_magnitude: got %0d bad cycles expected 0", m_mag_bad); end
  endtask

  task automatic test_polarity();
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0);
    pulse_finite();
    measure(200);
    n_vec++; if (m_ticks !== 4) begin n_err++; $display("FAIL unipolar_ticks: got %0d expected 4", m_ticks); end
    n_vec++; if (m_p1a !== 16'h0080) begin n_err++; $display("FAIL unipolar_p1_anodic: got %h expected 0080", m_p1a); end
    n_vec++; if (m_p1c !== 16'h0000) begin n_err++; $display("FAIL unipolar_p1_cathodic: got %h expected 0000", m_p1c); end
    n_vec++; if (m_p2c !== 16'h0080) begin n_err++; $display("FAIL unipolar_p2_cathodic: got %h expected 0080", m_p2c); end
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
    pulse_finite();
    measure(200);
    n_vec++; if (m_p1a !== 16'h0000) begin n_err++; $display("FAIL falling_p1_anodic: got %h expected 0000", m_p1a); end
    n_vec++; if (m_p1c !== 16'h0080) begin n_err++; $display("FAIL falling_p1_cathodic: got %h expected 0080", m_p1c); end
    n_vec++; if (m_p2a !== 16'h0080) begin n_err++; $display("FAIL falling_p2_anodic: got %h expected 0080", m_p2a); end
  endtask

  task automatic test_zero_skip();
    set_cfg(1, 0, 3, 4, 4, 0, 11, 1'b1, 1'b1);
    pulse_finite();
    measure(2000);
    n_vec++; if (m_ticks !== 101) begin n_err++; $display("FAIL skip_ticks: got %0d expected 101", m_ticks); end
    n_vec++; if (m_drive_ticks !== 32) begin n_err++; $display("FAIL skip_drive_ticks: got %0d expected 32", m_drive_ticks); end
    n_vec++; if (m_rec_cycles !== 0) begin n_err++; $display("FAIL skip_recovery_cycles: got %0d expected 0", m_rec_cycles); end
    n_vec++; if (m_swaps !== 16) begin n_err++; $display("FAIL skip_direct_swaps: got %0d expected 16", m_swaps); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL skip_done_count: got %0d expected 1", m_done); end
  endtask

  task automatic test_param_error();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_cfg(0, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0);
      else if (k == 1) set_cfg(1, 1, 1, 1, 0, 1, 1, 1'b1, 1'b0);
      else set_cfg(1, 1, 1, 0, 1, 1, 1, 1'b1, 1'b0);
      pulse_finite();
      n_vec++; if (param_error !== 1'b1) begin n_err++; $display("FAIL perr_pulse_%0d: got %b expected 1", k, param_error); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL perr_busy_%0d: got %b expected 0", k, busy); end
      @(posedge clk); #1;
      n_vec++; if (param_error !== 1'b0) begin n_err++; $display("FAIL perr_width_%0d: got %b expected 0", k, param_error); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL perr_busy_late_%0d: got %b expected 0", k, busy); end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0);
    pulse_finite();
    // Second start while busy with illegal settings: must be ignored, and the
    // run must keep using the values captured at the first start.
    pulse_length = '0;
    pulse_finite();
    measure(200);
    n_vec++; if (m_ticks !== 4) begin n_err++; $display("FAIL b2b_first_ticks: got %0d expected 4", m_ticks); end
    n_vec++; if (m_perr !== 0) begin n_err++; $display("FAIL b2b_ignored_start: got %0d param_error expected 0", m_perr); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL b2b_first_done: got %0d expected 1", m_done); end
    pulse_length = CNT_W'(2);
    pulse_finite();
    measure(200);
    n_vec++; if (m_ticks !== 6) begin n_err++; $display("FAIL b2b_second_ticks: got %0d expected 6", m_ticks); end
    n_vec++; if (m_drive_ticks !== 4) begin n_err++; $display("FAIL b2b_second_drive: got %0d expected 4", m_drive_ticks); end
  endtask

`ifdef RHS_STIM_INFINITE_EN
  task automatic test_infinite();
    set_cfg(1, 3, 3, 4, 0, 8, 11, 1'b1, 1'b1);
    stop_entry = 19;
    pulse_infinite(1'b0);
    measure(3000);
    stop_entry = 0;
    n_vec++; if (m_ticks !== 133) begin n_err++; $display("FAIL inf_stop_ticks: got %0d expected 133", m_ticks); end
    n_vec++; if (m_rec_ticks !== 24) begin n_err++; $display("FAIL inf_stop_recovery: got %0d expected 24", m_rec_ticks); end
    n_vec++; if (m_drive_ticks !== 24) begin n_err++; $display("FAIL inf_stop_drive: got %0d expected 24", m_drive_ticks); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL inf_stop_done: got %0d expected 1", m_done); end
    stop_in_gapt = 1'b1;
    pulse_infinite(1'b0);
    measure(3000);
    stop_in_gapt = 1'b0;
    n_vec++; if (m_ticks !== 38) begin n_err++; $display("FAIL gapt_stop_ticks: got %0d expected 38", m_ticks); end
    n_vec++; if (m_after_stop !== 1) begin n_err++; $display("FAIL gapt_stop_latency: got %0d expected 1", m_after_stop); end
    n_vec++; if (m_rec_ticks !== 8) begin n_err++; $display("FAIL gapt_stop_recovery: got %0d expected 8", m_rec_ticks); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL gapt_stop_done: got %0d expected 1", m_done); end
    pulse_infinite(1'b1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_with_stop: got busy %b expected 0", busy); end
  endtask
`else
  task automatic test_infinite();
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b0);
    pulse_infinite(1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL inf_ignored_busy: got %b expected 0", busy); end
    n_vec++; if (param_error !== 1'b0) begin n_err++; $display("FAIL inf_ignored_perr: got %b expected 0", param_error); end
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL inf_ignored_busy_late: got %b expected 0", busy); end
  endtask
`endif

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    set_cfg(1, 3, 3, 4, 4, 8, 11, 1'b1, 1'b1);
    pulse_finite();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (drive_anodic != '0) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL rst_mid_phase1_reached: got no drive expected drive"); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (drive_anodic !== 16'h0) begin n_err++; $display("FAIL rst_mid_anodic: got %h expected 0", drive_anodic); end
    n_vec++; if (drive_cathodic !== 16'h0) begin n_err++; $display("FAIL rst_mid_cathodic: got %h expected 0", drive_cathodic); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    set_cfg(1, 3, 3, 4, 4, 8, 11, 1'b1, 1'b1);
    pulse_finite();
    measure(2000);
    n_vec++; if (m_ticks !== 181) begin n_err++; $display("FAIL rst_after_ticks: got %0d expected 181", m_ticks); end
    n_vec++; if (m_done !== 1) begin n_err++; $display("FAIL rst_after_done: got %0d expected 1", m_done); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rstn           = 1'b0;
    finite_start   = 1'b0;
    infinite_start = 1'b0;
    infinite_stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_sequence();
    test_polarity();
    test_zero_skip();
    test_param_error();
    test_back_to_back();
    test_infinite();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
